// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
// Holds the FSM encoding, default sizing and the per-digit add-3 rule.
package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BIN_W_DEF  = 14;
  localparam int DIGITS_DEF = 4;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  localparam int MAX_VAL = pow10(DIGITS_DEF) - 1;
  localparam int BCD_W   = 4 * DIGITS_DEF;
  localparam int CNT_W   = $clog2(BIN_W_DEF);

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3_digit.sv
// One BCD digit's add-3 correction, applied before each left shift.
// Purely combinational; no carry into the neighbouring digit.
module bcd_add3_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = add3(d_i);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/done handshake.
// Result registers only change on a done edge or reset so a display never sees partial values.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int L_BCD_W = 4 * DIGITS;
  localparam int L_MAX   = pow10(DIGITS) - 1;
  localparam int L_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [L_CNT_W-1:0] L_LAST = L_CNT_W'(BIN_W - 1);
  localparam logic [L_BCD_W-1:0] L_SAT  = {DIGITS{4'h9}};

  state_t                   r_state;
  logic [BIN_W-1:0]         r_bin;
  logic [L_BCD_W-1:0]       r_bcd_sh;
  logic [L_CNT_W-1:0]       r_cnt;
  logic                     r_ovf_flag;
  logic                     r_busy;
  logic                     r_done;
  logic [L_BCD_W-1:0]       r_bcd;
  logic                     r_ovf;

  state_t                   w_state_nxt;
  logic [BIN_W-1:0]         w_bin_nxt;
  logic [L_BCD_W-1:0]       w_bcd_sh_nxt;
  logic [L_CNT_W-1:0]       w_cnt_nxt;
  logic                     w_ovf_flag_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic [L_BCD_W-1:0]       w_bcd_nxt;
  logic                     w_ovf_nxt;

  logic [L_BCD_W-1:0]       w_adj;
  logic [L_BCD_W+BIN_W-1:0] w_shifted;
  logic                     w_in_ovf;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3_digit u_add3 (
        .d_i (r_bcd_sh[4*g +: 4]),
        .d_o (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected BCD field concatenated with the binary field, then shifted left once.
  assign w_shifted = {w_adj, r_bin} << 1;
  assign w_in_ovf  = (32'(bin_i) > 32'(L_MAX));

  // Next-state and next-datapath logic for the IDLE/SHIFT controller.
  always_comb begin
    w_state_nxt    = r_state;
    w_bin_nxt      = r_bin;
    w_bcd_sh_nxt   = r_bcd_sh;
    w_cnt_nxt      = r_cnt;
    w_ovf_flag_nxt = r_ovf_flag;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_bcd_nxt      = r_bcd;
    w_ovf_nxt      = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt    = ST_SHIFT;
          w_bin_nxt      = bin_i;
          w_bcd_sh_nxt   = {L_BCD_W{1'b0}};
          w_cnt_nxt      = {L_CNT_W{1'b0}};
          w_ovf_flag_nxt = w_in_ovf;
          w_busy_nxt     = 1'b1;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_bin_nxt    = w_shifted[BIN_W-1:0];
        w_bcd_sh_nxt = w_shifted[L_BCD_W+BIN_W-1:BIN_W];
        if (r_cnt == L_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {L_CNT_W{1'b0}};
          w_done_nxt  = 1'b1;
          w_bcd_nxt   = r_ovf_flag ? L_SAT : w_shifted[L_BCD_W+BIN_W-1:BIN_W];
          w_ovf_nxt   = r_ovf_flag;
        end else begin
          w_cnt_nxt   = r_cnt + L_CNT_W'(1);
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset also aborts a conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bin      <= {BIN_W{1'b0}};
      r_bcd_sh   <= {L_BCD_W{1'b0}};
      r_cnt      <= {L_CNT_W{1'b0}};
      r_ovf_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= {L_BCD_W{1'b0}};
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bin      <= w_bin_nxt;
      r_bcd_sh   <= w_bcd_sh_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_flag <= w_ovf_flag_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_bcd      <= w_bcd_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign bcd_o  = r_bcd;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, values, saturation, ignored starts,
// back-to-back acceptance and reset abort, with hand-computed expectations.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [13:0] bin_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bcd_o;
  logic        ovf_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n;
  int hits;

  bin2bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) for done_o, checking outputs stay held while busy; returns ticks taken.
  task automatic wait_done(output int cnt);
    logic [15:0] held_bcd;
    logic        held_ovf;
    held_bcd = bcd_o;
    held_ovf = ovf_o;
    cnt = 0;
    while (cnt < 30) begin
      tick();
      cnt++;
      if (done_o) break;
      chk("held_bcd", 32'(bcd_o), 32'(held_bcd));
      chk("held_ovf", 32'(ovf_o), 32'(held_ovf));
      chk("busy_mid", 32'(busy_o), 32'd1);
    end
  endtask

  task automatic conv(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    start_i = 1'b1;
    bin_i   = v;
    tick();
    start_i = 1'b0;
    bin_i   = 14'(~v);
    chk("busy_start", 32'(busy_o), 32'd1);
    wait_done(lat);
    chk("latency", 32'(lat), 32'd14);
    chk("done", 32'(done_o), 32'd1);
    chk("busy_done", 32'(busy_o), 32'd0);
    chk("bcd", 32'(bcd_o), 32'(exp_bcd));
    chk("ovf", 32'(ovf_o), 32'(exp_ovf));
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    bin_i   = 14'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_bcd", 32'(bcd_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);

    conv(14'd1234, 16'h1234, 1'b0);
    tick();
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("bcd_hold", 32'(bcd_o), 32'h1234);
    conv(14'd0, 16'h0000, 1'b0);
    conv(14'd5678, 16'h5678, 1'b0);
    conv(14'd9999, 16'h9999, 1'b0);
    conv(14'd12000, 16'h9999, 1'b1);
    conv(14'd42, 16'h0042, 1'b0);
    conv(14'd10000, 16'h9999, 1'b1);
    conv(14'd1, 16'h0001, 1'b0);
    conv(14'd16383, 16'h9999, 1'b1);
    conv(14'd909, 16'h0909, 1'b0);

    // Start pulse mid-conversion must be ignored.
    tick();
    start_i = 1'b1;
    bin_i   = 14'd1234;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    start_i = 1'b1;
    bin_i   = 14'd8888;
    tick();
    start_i = 1'b0;
    bin_i   = 14'd0;
    wait_done(n);
    chk("ign_latency", 32'(n), 32'd9);
    chk("ign_bcd", 32'(bcd_o), 32'h1234);
    chk("ign_done", 32'(done_o), 32'd1);
    tick();
    chk("ign_no_restart", 32'(busy_o), 32'd0);

    // Start asserted during the done cycle is accepted.
    conv(14'd7, 16'h0007, 1'b0);
    start_i = 1'b1;
    bin_i   = 14'd4321;
    tick();
    start_i = 1'b0;
    chk("b2b_done_low", 32'(done_o), 32'd0);
    chk("b2b_busy", 32'(busy_o), 32'd1);
    wait_done(n);
    chk("b2b_gap", 32'(n + 1), 32'd15);
    chk("b2b_bcd", 32'(bcd_o), 32'h4321);
    tick();

    // Reset mid-conversion aborts with no done pulse.
    start_i = 1'b1;
    bin_i   = 14'd5678;
    tick();
    start_i = 1'b0;
    repeat (6) tick();
    chk("abort_busy_pre", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_bcd", 32'(bcd_o), 32'd0);
    chk("abort_ovf", 32'(ovf_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    hits = 0;
    repeat (20) begin
      tick();
      if (done_o) hits++;
    end
    chk("abort_no_done", 32'(hits), 32'd0);

    // Reset and start together: reset wins.
    rst     = 1'b1;
    start_i = 1'b1;
    bin_i   = 14'd77;
    tick();
    rst     = 1'b0;
    start_i = 1'b0;
    chk("rst_start_busy", 32'(busy_o), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(busy_o), 32'd0);
    conv(14'd8051, 16'h8051, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
